// File: rtl/scmp_bus_pkg.sv
// Shared types and helpers for the SC/MP external-bus cycle controller.
package scmp_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ADDR,
        ST_STRB,
        ST_DONE
    } bus_state_e;

    typedef enum logic [1:0] {
        DIR_RD,
        DIR_WR,
        DIR_ADDR_ONLY
    } bus_dir_e;

    // Bit positions of the status flags in the byte shown on DB during ADDR.
    localparam int STAT_H = 7;
    localparam int STAT_D = 6;
    localparam int STAT_I = 5;
    localparam int STAT_R = 4;

    // A request with both rd and wr set is treated as a read.
    function automatic bus_dir_e decode_dir(input logic rd, input logic wr);
        bus_dir_e dir;
        dir = DIR_ADDR_ONLY;
        if (rd)
            dir = DIR_RD;
        else if (wr)
            dir = DIR_WR;
        return dir;
    endfunction

    function automatic logic [7:0] status_byte(input logic h, input logic d,
                                               input logic i, input logic r,
                                               input logic [3:0] addr_hi);
        logic [7:0] s;
        s         = '0;
        s[STAT_H] = h;
        s[STAT_D] = d;
        s[STAT_I] = i;
        s[STAT_R] = r;
        s[3:0]    = addr_hi;
        return s;
    endfunction

endpackage

// File: rtl/scmp_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module scmp_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sr <= {STAGES{RST_VAL}};
        else
            sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/scmp_bus_ctl.sv
// SC/MP external-bus cycle controller: arbitration, NADS/NRDS/NWDS timing
// with NHOLD wait states, and read-data return to the microcode sequencer.
module scmp_bus_ctl
    import scmp_bus_pkg::*;
#(
    parameter int ADS_CYCLES    = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ads_req,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic        f_r,
    input  logic        f_i,
    input  logic        f_d,
    input  logic        f_h,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        req_err,
    output logic        nbreq_n,
    input  logic        nenin_n,
    output logic        nenout_n,
    input  logic        nhold_n,
    output logic        nads_n,
    output logic        nrds_n,
    output logic        nwds_n,
    output logic [11:0] a_out,
    output logic [7:0]  db_out,
    output logic        db_oe,
    input  logic [7:0]  db_in
);

    localparam int CNT_W = 3;

    bus_state_e        state_q, state_d;
    bus_dir_e          dir_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       addr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        stat_q;
    logic [7:0]        rdata_q;
    logic              req_err_q;
    logic              accept;
    logic              rd_capture;
    logic              nenin_s;
    logic              nhold_s;

    scmp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nenin (
        .clk (clk),
        .rst (rst),
        .d   (nenin_n),
        .q   (nenin_s)
    );

    scmp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_nhold (
        .clk (clk),
        .rst (rst),
        .d   (nhold_n),
        .q   (nhold_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        rd_capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ads_req) begin
                    accept  = 1'b1;
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (!nenin_s) begin
                    state_d = ST_ADDR;
                    cnt_d   = CNT_W'(ADS_CYCLES - 1);
                end
            end
            ST_ADDR: begin
                if (cnt_q == '0) begin
                    if (dir_q == DIR_ADDR_ONLY) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STRB;
                        cnt_d   = CNT_W'(STROBE_CYCLES - 1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STRB: begin
                // Minimum width first; NHOLD only stretches once it has elapsed.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (nhold_s) begin
                    state_d    = ST_DONE;
                    rd_capture = (dir_q == DIR_RD);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dir_q     <= DIR_ADDR_ONLY;
            req_err_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_err_q <= accept & rd_req & wr_req;
            if (accept)
                dir_q <= decode_dir(rd_req, wr_req);
            if (rd_capture)
                rdata_q <= db_in;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            stat_q  <= status_byte(f_h, f_d, f_i, f_r, addr[15:12]);
        end
    end

    // Outputs decode directly from state so an asynchronous reset clears every strobe at once.
    always_comb begin
        nbreq_n     = 1'b1;
        nads_n      = 1'b1;
        nrds_n      = 1'b1;
        nwds_n      = 1'b1;
        a_out       = '0;
        db_out      = '0;
        db_oe       = 1'b0;
        rdata_valid = 1'b0;
        case (state_q)
            ST_ARB: nbreq_n = 1'b0;
            ST_ADDR: begin
                nbreq_n = 1'b0;
                nads_n  = 1'b0;
                a_out   = addr_q[11:0];
                db_out  = stat_q;
                db_oe   = 1'b1;
            end
            ST_STRB: begin
                nbreq_n = 1'b0;
                a_out   = addr_q[11:0];
                if (dir_q == DIR_RD) begin
                    nrds_n = 1'b0;
                end else begin
                    nwds_n = 1'b0;
                    db_out = wdata_q;
                    db_oe  = 1'b1;
                end
            end
            ST_DONE: rdata_valid = (dir_q == DIR_RD);
            default: ;
        endcase
    end

    assign busy     = ((state_q == ST_IDLE) & ads_req) | (state_q == ST_ARB) |
                      (state_q == ST_ADDR) | (state_q == ST_STRB);
    assign nenout_n = nenin_s | (state_q != ST_IDLE) | ads_req;
    assign rdata    = rdata_q;
    assign req_err  = req_err_q;

endmodule

// File: tb/tb_scmp_bus_ctl.sv
// Bench for scmp_bus_ctl: directed scenarios plus randomized bus cycles
// checked against a phase-timeline model derived from the cycle rules.
module tb_scmp_bus_ctl;

    localparam int S   = 2;
    localparam int ADS = 1;
    localparam int STB = 2;
    localparam int N   = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ads_req = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
    logic        f_r = 1'b0, f_i = 1'b0, f_d = 1'b0, f_h = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        busy;
    logic [7:0]  rdata;
    logic        rdata_valid, req_err, nbreq_n, nenout_n;
    logic        nenin_n = 1'b1, nhold_n = 1'b1;
    logic        nads_n, nrds_n, nwds_n, db_oe;
    logic [11:0] a_out;
    logic [7:0]  db_out;
    logic [7:0]  db_in = '0;

    scmp_bus_ctl #(.ADS_CYCLES(ADS), .STROBE_CYCLES(STB), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .ads_req(ads_req), .rd_req(rd_req), .wr_req(wr_req),
        .f_r(f_r), .f_i(f_i), .f_d(f_d), .f_h(f_h), .addr(addr), .wdata(wdata),
        .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid), .req_err(req_err),
        .nbreq_n(nbreq_n), .nenin_n(nenin_n), .nenout_n(nenout_n), .nhold_n(nhold_n),
        .nads_n(nads_n), .nrds_n(nrds_n), .nwds_n(nwds_n), .a_out(a_out),
        .db_out(db_out), .db_oe(db_oe), .db_in(db_in)
    );

    always #5 clk = ~clk;

    int         nvec = 0;
    int         nfail = 0;
    int         cyc = 0;
    logic       nen_h[N];
    logic       nh_h[N];
    logic [7:0] db_h[N];
    logic [7:0] exp_rdata = '0;

    // Value seen by the controller in cycle c: the input driven S cycles earlier.
    function automatic logic nen_s(input int c);
        return (c - S >= 0) ? nen_h[c-S] : 1'b1;
    endfunction

    function automatic logic nh_s(input int c);
        return (c - S >= 0) ? nh_h[c-S] : 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc > N - 100) begin
            $display("FAIL cycle_budget cycle %0d: observed overrun expected < %0d", cyc, N - 100);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    // ph: 0 idle, 1 idle+request, 2 arbitration, 3 address, 4 strobe, 5 done
    task automatic check_cycle(input int ph, input logic rd, input logic wr,
                               input logic [15:0] a, input logic [7:0] wd,
                               input logic [3:0] fl, input logic err_exp);
        logic is_wr;
        logic [7:0] e_db;
        is_wr = wr && !rd;
        e_db  = (ph == 3) ? {fl, a[15:12]} : ((ph == 4 && is_wr) ? wd : 8'h00);
        chk("nbreq_n",  16'(nbreq_n),  16'(!(ph == 2 || ph == 3 || ph == 4)));
        chk("nads_n",   16'(nads_n),   16'(ph != 3));
        chk("nrds_n",   16'(nrds_n),   16'(!(ph == 4 && rd)));
        chk("nwds_n",   16'(nwds_n),   16'(!(ph == 4 && is_wr)));
        chk("db_oe",    16'(db_oe),    16'(ph == 3 || (ph == 4 && is_wr)));
        chk("a_out",    16'(a_out),    (ph == 3 || ph == 4) ? 16'(a[11:0]) : 16'h0);
        chk("db_out",   16'(db_out),   16'(e_db));
        chk("busy",     16'(busy),     16'(ph >= 1 && ph <= 4));
        chk("nenout_n", 16'(nenout_n), (ph == 0) ? 16'(nen_s(cyc)) : 16'h1);
        chk("rdata_valid", 16'(rdata_valid), 16'(ph == 5 && rd));
        chk("rdata",    16'(rdata),    16'(exp_rdata));
        chk("req_err",  16'(req_err),  16'(err_exp));
    endtask

    task automatic idle(input int n, input int nen_mode);
        for (int i = 0; i < n; i++) begin
            nen_h[cyc] = (nen_mode < 0) ? 1'($urandom_range(1, 0)) : 1'(nen_mode);
            nh_h[cyc]  = 1'b1;
            db_h[cyc]  = 8'($urandom);
            ads_req = 1'b0;
            rd_req  = 1'($urandom_range(1, 0));
            wr_req  = 1'($urandom_range(1, 0));
            addr    = 16'($urandom);
            nenin_n = nen_h[cyc];
            nhold_n = nh_h[cyc];
            db_in   = db_h[cyc];
            @(negedge clk);
            check_cycle(0, 1'b0, 1'b0, 16'h0, 8'h0, 4'h0, 1'b0);
            tick();
        end
    endtask

    // k: cycles nenin_n stays high from the request; hs/hl: nhold_n low window
    // relative to the request; rst_rel: cycle offset at which reset hits (-1 none).
    task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [7:0] wd, input logic [3:0] fl, input int k,
                           input int hs, input int hl, input bit rnd,
                           input int rst_rel, input int dbv);
        int A, arb_last, addr_last, ex, done, ph;
        A = cyc;
        for (int c = A; c <= A + 60; c++) begin
            if (c < A + k)
                nen_h[c] = 1'b1;
            else if (rnd && c > A + k)
                nen_h[c] = 1'($urandom_range(1, 0));
            else
                nen_h[c] = 1'b0;
            if (rnd)
                nh_h[c] = (c < A + 30) ? ($urandom_range(2, 0) != 0) : 1'b1;
            else
                nh_h[c] = !(c >= A + hs && c < A + hs + hl);
            db_h[c] = (dbv < 0) ? 8'($urandom) : 8'(dbv);
        end
        arb_last = A + 1;
        while (nen_s(arb_last) && arb_last < A + 60) arb_last++;
        addr_last = arb_last + ADS;
        ex = -1;
        if (rd || wr) begin
            ex = addr_last + STB;
            while (!nh_s(ex) && ex < A + 60) ex++;
            done = ex + 1;
        end else begin
            done = addr_last + 1;
        end
        for (int c = A; c <= done; c++) begin
            if (c == A)              ph = 1;
            else if (c <= arb_last)  ph = 2;
            else if (c <= addr_last) ph = 3;
            else if (c < done)       ph = 4;
            else                     ph = 5;
            if (c == A) begin
                ads_req = 1'b1; rd_req = rd; wr_req = wr; addr = a; wdata = wd;
                {f_h, f_d, f_i, f_r} = fl;
            end else begin
                ads_req = 1'($urandom_range(1, 0));
                rd_req  = 1'($urandom_range(1, 0));
                wr_req  = 1'($urandom_range(1, 0));
                addr    = 16'($urandom);
                wdata   = 8'($urandom);
                {f_h, f_d, f_i, f_r} = 4'($urandom);
            end
            nenin_n = nen_h[c];
            nhold_n = nh_h[c];
            db_in   = db_h[c];
            if (c == done && rd)
                exp_rdata = db_h[ex];
            @(negedge clk);
            check_cycle(ph, rd, wr, a, wd, fl, (c == A + 1) && rd && wr);
            if (c - A == rst_rel) begin
                #2;
                ads_req = 1'b0;
                rst = 1'b1;
                #1;
                chk("rst_nrds_n", 16'(nrds_n),  16'h1);
                chk("rst_nwds_n", 16'(nwds_n),  16'h1);
                chk("rst_db_oe",  16'(db_oe),   16'h0);
                chk("rst_nbreq_n", 16'(nbreq_n), 16'h1);
                chk("rst_nads_n", 16'(nads_n),  16'h1);
                chk("rst_busy",   16'(busy),    16'h0);
                exp_rdata = 8'h00;
                tick();
                nenin_n = nen_h[cyc];
                nhold_n = nh_h[cyc];
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("rst_rdata", 16'(rdata), 16'h0);
                chk("rst_rdata_valid", 16'(rdata_valid), 16'h0);
                chk("rst_req_err", 16'(req_err), 16'h0);
                for (int j = cyc + 1 - S; j < cyc; j++) begin
                    nen_h[j] = 1'b1;
                    nh_h[j]  = 1'b1;
                end
                tick();
                return;
            end
            tick();
        end
    endtask

    initial begin
        logic [1:0] kind;
        for (int i = 0; i < N; i++) begin
            nen_h[i] = 1'b1;
            nh_h[i]  = 1'b1;
            db_h[i]  = 8'h00;
        end
        cyc = 8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cycle(0, 1'b0, 1'b0, 16'h0, 8'h0, 4'h0, 1'b0);
        rst = 1'b0;
        cyc = 9;
        tick();

        // Read with bus already granted.
        idle(5, 0);
        run_txn(1'b1, 1'b0, 16'hA123, 8'h00, 4'b1001, 0, 0, 0, 1'b0, -1, 8'h5A);
        // Write with NHOLD wait states.
        idle(2, 0);
        run_txn(1'b0, 1'b1, 16'h4567, 8'h3C, 4'b0110, 0, 2, 3, 1'b0, -1, 8'hEE);
        // Arbitration wait.
        idle(4, 1);
        run_txn(1'b1, 1'b0, 16'h0FF0, 8'h00, 4'b0011, 4, 0, 0, 1'b0, -1, 8'hC3);
        // Malformed request, then address-only.
        idle(2, 0);
        run_txn(1'b1, 1'b1, 16'hBEEF, 8'h77, 4'b1111, 0, 0, 0, 1'b0, -1, 8'h81);
        run_txn(1'b0, 1'b0, 16'h1234, 8'h55, 4'b0100, 0, 0, 0, 1'b0, -1, 8'h00);
        // Reset during the strobe, then a clean read.
        idle(3, 0);
        run_txn(1'b1, 1'b0, 16'h2222, 8'h00, 4'b0000, 0, 0, 0, 1'b0, 3, 8'h99);
        idle(4, 0);
        run_txn(1'b1, 1'b0, 16'hA123, 8'h00, 4'b1001, 0, 0, 0, 1'b0, -1, 8'h5A);

        for (int t = 0; t < 40; t++) begin
            idle($urandom_range(2, 0), -1);
            kind = 2'($urandom);
            run_txn(kind == 2'd0 || kind == 2'd2, kind == 2'd1 || kind == 2'd2,
                    16'($urandom), 8'($urandom), 4'($urandom),
                    $urandom_range(3, 0), 0, 0, 1'b1, -1, -1);
        end
        idle(3, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
